// File: rtl/axi_lite_xbar_1to2_if.sv
// AXI4-Lite bundle (32-bit address/data, 4-bit write mask, 2-bit response).
// The master modport drives requests; the slave modport drives ready/response signals.
interface axi_lite_if;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awvalid, wdata, wmask, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wmask, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_xbar_1to2.sv
// AXI4-Lite 1:2 address-decoding demux with internal DECERR completion.
// Independent read and write paths, one outstanding transaction each.
module axi_lite_xbar_1to2 #(
   parameter logic [31:0] S0_BASE = 32'h8000_0000,
   parameter logic [31:0] S0_MASK = 32'hF800_0000,
   parameter logic [31:0] S1_BASE = 32'hA000_0000,
   parameter logic [31:0] S1_MASK = 32'hFFFF_0000,
   parameter logic [1:0]  DECERR  = 2'b11
) (
   input  logic        clk,
   input  logic        reset,
   axi_lite_if.slave   m,
   axi_lite_if.master  s0,
   axi_lite_if.master  s1,
   output logic [7:0]  dec_err_cnt,
   output logic [31:0] dec_err_addr
);
   typedef enum logic [1:0] {TgtS0, TgtS1, TgtErr} tgt_e;
   typedef enum logic [1:0] {RdIdle, RdS0, RdS1, RdErr} rd_state_e;
   typedef enum logic [1:0] {WrIdle, WrData, WrResp} wr_state_e;

   // S0 wins when both windows match.
   function automatic tgt_e decode(input logic [31:0] addr);
      if ((addr & S0_MASK) == S0_BASE) return TgtS0;
      else if ((addr & S1_MASK) == S1_BASE) return TgtS1;
      else return TgtErr;
   endfunction

   rd_state_e   rd_state_q, rd_state_d;
   wr_state_e   wr_state_q, wr_state_d;
   tgt_e        wsel_q, wsel_d;
   tgt_e        rd_tgt, wr_tgt;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [8:0]  err_sum;
   logic        rd_err, wr_err;

   // Ungated handshake controls; reset gating is applied on the port assigns.
   logic m_arready, m_rvalid, s0_arvalid, s1_arvalid, s0_rready, s1_rready;
   logic m_awready, m_wready, m_bvalid, s0_awvalid, s1_awvalid, s0_wvalid, s1_wvalid;
   logic s0_bready, s1_bready;

   assign s0.araddr = m.araddr;
   assign s1.araddr = m.araddr;
   assign s0.awaddr = m.awaddr;
   assign s1.awaddr = m.awaddr;
   assign s0.wdata  = m.wdata;
   assign s1.wdata  = m.wdata;
   assign s0.wmask  = m.wmask;
   assign s1.wmask  = m.wmask;

   always_comb begin
      rd_state_d = rd_state_q;
      rd_tgt     = decode(m.araddr);
      m_arready  = 1'b0;
      m_rvalid   = 1'b0;
      s0_arvalid = 1'b0;
      s1_arvalid = 1'b0;
      s0_rready  = 1'b0;
      s1_rready  = 1'b0;
      m.rdata    = '0;
      m.rresp    = '0;
      case (rd_state_q)
         RdIdle: begin
            unique case (rd_tgt)
               TgtS0: begin
                  s0_arvalid = m.arvalid;
                  m_arready  = s0.arready;
               end
               TgtS1: begin
                  s1_arvalid = m.arvalid;
                  m_arready  = s1.arready;
               end
               default: m_arready = 1'b1;
            endcase
            if (m.arvalid && m_arready) begin
               unique case (rd_tgt)
                  TgtS0:   rd_state_d = RdS0;
                  TgtS1:   rd_state_d = RdS1;
                  default: rd_state_d = RdErr;
               endcase
            end
         end
         RdS0: begin
            m_rvalid  = s0.rvalid;
            m.rdata   = s0.rdata;
            m.rresp   = s0.rresp;
            s0_rready = m.rready;
            if (s0.rvalid && m.rready) rd_state_d = RdIdle;
         end
         RdS1: begin
            m_rvalid  = s1.rvalid;
            m.rdata   = s1.rdata;
            m.rresp   = s1.rresp;
            s1_rready = m.rready;
            if (s1.rvalid && m.rready) rd_state_d = RdIdle;
         end
         RdErr: begin
            m_rvalid = 1'b1;
            m.rresp  = DECERR;
            if (m.rready) rd_state_d = RdIdle;
         end
         default: rd_state_d = RdIdle;
      endcase
   end

   always_comb begin
      wr_state_d = wr_state_q;
      wsel_d     = wsel_q;
      wr_tgt     = decode(m.awaddr);
      m_awready  = 1'b0;
      m_wready   = 1'b0;
      m_bvalid   = 1'b0;
      s0_awvalid = 1'b0;
      s1_awvalid = 1'b0;
      s0_wvalid  = 1'b0;
      s1_wvalid  = 1'b0;
      s0_bready  = 1'b0;
      s1_bready  = 1'b0;
      m.bresp    = '0;
      case (wr_state_q)
         WrIdle: begin
            // W only travels alongside a pending AW, never ahead of it.
            unique case (wr_tgt)
               TgtS0: begin
                  s0_awvalid = m.awvalid;
                  s0_wvalid  = m.wvalid & m.awvalid;
                  m_awready  = s0.awready;
                  m_wready   = m.awvalid & s0.wready;
               end
               TgtS1: begin
                  s1_awvalid = m.awvalid;
                  s1_wvalid  = m.wvalid & m.awvalid;
                  m_awready  = s1.awready;
                  m_wready   = m.awvalid & s1.wready;
               end
               default: begin
                  m_awready = 1'b1;
                  m_wready  = m.awvalid;
               end
            endcase
            if (m.awvalid && m_awready) begin
               wsel_d     = wr_tgt;
               wr_state_d = (m.wvalid && m_wready) ? WrResp : WrData;
            end
         end
         WrData: begin
            unique case (wsel_q)
               TgtS0: begin
                  s0_wvalid = m.wvalid;
                  m_wready  = s0.wready;
               end
               TgtS1: begin
                  s1_wvalid = m.wvalid;
                  m_wready  = s1.wready;
               end
               default: m_wready = 1'b1;
            endcase
            if (m.wvalid && m_wready) wr_state_d = WrResp;
         end
         WrResp: begin
            unique case (wsel_q)
               TgtS0: begin
                  m_bvalid  = s0.bvalid;
                  m.bresp   = s0.bresp;
                  s0_bready = m.bready;
               end
               TgtS1: begin
                  m_bvalid  = s1.bvalid;
                  m.bresp   = s1.bresp;
                  s1_bready = m.bready;
               end
               default: begin
                  m_bvalid = 1'b1;
                  m.bresp  = DECERR;
               end
            endcase
            if (m_bvalid && m.bready) wr_state_d = WrIdle;
         end
         default: wr_state_d = WrIdle;
      endcase
   end

   assign rd_err = (rd_state_q == RdIdle) && m.arvalid && m_arready && (rd_tgt == TgtErr);
   assign wr_err = (wr_state_q == WrIdle) && m.awvalid && m_awready && (wr_tgt == TgtErr);

   always_comb begin
      err_sum = {1'b0, cnt_q} + {8'd0, rd_err} + {8'd0, wr_err};
      cnt_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
      addr_d  = wr_err ? m.awaddr : (rd_err ? m.araddr : addr_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_state_q <= RdIdle;
         wr_state_q <= WrIdle;
         wsel_q     <= TgtErr;
         cnt_q      <= 8'd0;
         addr_q     <= 32'd0;
      end else begin
         rd_state_q <= rd_state_d;
         wr_state_q <= wr_state_d;
         wsel_q     <= wsel_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
      end
   end

   assign dec_err_cnt  = cnt_q;
   assign dec_err_addr = addr_q;

   assign m.arready  = reset & m_arready;
   assign m.rvalid   = reset & m_rvalid;
   assign m.awready  = reset & m_awready;
   assign m.wready   = reset & m_wready;
   assign m.bvalid   = reset & m_bvalid;
   assign s0.arvalid = reset & s0_arvalid;
   assign s1.arvalid = reset & s1_arvalid;
   assign s0.rready  = reset & s0_rready;
   assign s1.rready  = reset & s1_rready;
   assign s0.awvalid = reset & s0_awvalid;
   assign s1.awvalid = reset & s1_awvalid;
   assign s0.wvalid  = reset & s0_wvalid;
   assign s1.wvalid  = reset & s1_wvalid;
   assign s0.bready  = reset & s0_bready;
   assign s1.bready  = reset & s1_bready;
endmodule

// File: tb/tb_axi_lite_xbar_1to2.sv
// Directed bench for axi_lite_xbar_1to2: behavioural slaves plus a response scoreboard.
module tb_axi_lite_xbar_1to2;
   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  cnt;
   logic [31:0] eaddr;

   always #5 clk = ~clk;

   axi_lite_if m_if ();
   axi_lite_if s_if [2] ();

   axi_lite_xbar_1to2 dut (
      .clk         (clk),
      .reset       (reset),
      .m           (m_if),
      .s0          (s_if[0]),
      .s1          (s_if[1]),
      .dec_err_cnt (cnt),
      .dec_err_addr(eaddr)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } rexp_t;

   rexp_t       rq[$];
   logic [1:0]  bq[$];
   int          checks = 0;
   int          failures = 0;
   int unsigned rd_delay[2];
   int unsigned b_delay[2];
   logic [31:0] slv_rdata[2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Slave models: update #1 after posedge, handshakes sampled on the preceding negedge.
   for (genvar g = 0; g < 2; g++) begin : g_slv
      int unsigned ar_cnt = 0, aw_cnt = 0, w_cnt = 0, arv_cnt = 0, awv_cnt = 0;
      logic [31:0] last_awaddr = '0, last_wdata = '0;
      logic [3:0]  last_wmask = '0;
      initial begin
         bit          ar_hs, r_hs, aw_hs, w_hs, b_hs, rd_pend, aw_got, w_got, b_pend;
         int unsigned rd_wait, b_wait;
         rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; rd_wait = 0; b_wait = 0;
         s_if[g].arready = 0; s_if[g].rvalid = 0; s_if[g].rdata = '0; s_if[g].rresp = '0;
         s_if[g].awready = 0; s_if[g].wready = 0; s_if[g].bvalid = 0; s_if[g].bresp = '0;
         forever begin
            @(negedge clk);
            ar_hs = s_if[g].arvalid && s_if[g].arready;
            r_hs  = s_if[g].rvalid && s_if[g].rready;
            aw_hs = s_if[g].awvalid && s_if[g].awready;
            w_hs  = s_if[g].wvalid && s_if[g].wready;
            b_hs  = s_if[g].bvalid && s_if[g].bready;
            if (s_if[g].arvalid) arv_cnt++;
            if (s_if[g].awvalid) awv_cnt++;
            if (aw_hs) last_awaddr = s_if[g].awaddr;
            if (w_hs) begin
               last_wdata = s_if[g].wdata;
               last_wmask = s_if[g].wmask;
            end
            @(posedge clk);
            #1;
            if (!reset) begin
               rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
               s_if[g].arready = 0; s_if[g].rvalid = 0;
               s_if[g].awready = 0; s_if[g].wready = 0; s_if[g].bvalid = 0;
            end else begin
               if (ar_hs) begin
                  ar_cnt++;
                  rd_pend = 1;
                  rd_wait = rd_delay[g];
               end
               if (r_hs) s_if[g].rvalid = 0;
               if (rd_pend) begin
                  if (rd_wait == 0) begin
                     s_if[g].rvalid = 1;
                     s_if[g].rdata  = slv_rdata[g];
                     rd_pend = 0;
                  end else rd_wait--;
               end
               s_if[g].arready = !rd_pend && !s_if[g].rvalid;
               if (aw_hs) begin aw_cnt++; aw_got = 1; end
               if (w_hs) begin w_cnt++; w_got = 1; end
               if (b_hs) begin
                  s_if[g].bvalid = 0;
                  aw_got = 0;
                  w_got = 0;
               end
               if (aw_got && w_got && !s_if[g].bvalid && !b_pend) begin
                  b_pend = 1;
                  b_wait = b_delay[g];
               end
               if (b_pend) begin
                  if (b_wait == 0) begin
                     s_if[g].bvalid = 1;
                     b_pend = 0;
                  end else b_wait--;
               end
               s_if[g].awready = !aw_got;
               s_if[g].wready  = !w_got;
            end
         end
      end
   end

   task automatic rd(input logic [31:0] addr, input logic [31:0] edata, input logic [1:0] eresp,
                     input string tag);
      bit    got_r = 0, ar_now;
      int    cyc = 0;
      rexp_t e;
      rq.push_back({edata, eresp});
      m_if.araddr = addr; m_if.arvalid = 1; m_if.rready = 1;
      while (!got_r && cyc < 50) begin
         @(negedge clk);
         ar_now = m_if.arvalid && m_if.arready;
         if (m_if.rvalid && m_if.rready) begin
            e = rq.pop_front();
            check({tag, "_rdata"}, m_if.rdata, e.data);
            check({tag, "_rresp"}, 32'(m_if.rresp), 32'(e.resp));
            got_r = 1;
         end
         @(posedge clk);
         #1;
         if (ar_now) m_if.arvalid = 0;
         cyc++;
      end
      m_if.arvalid = 0; m_if.rready = 0;
      check({tag, "_rdone"}, 32'(got_r), 32'd1);
   endtask

   // probe_aw keeps a second AW pending after the first is accepted to prove it is blocked.
   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
                     input int w_delay, input bit probe_aw, input logic [1:0] eresp,
                     input string tag);
      bit         aw_done = 0, w_done = 0, b_done = 0, aw_now, w_now;
      int         cyc = 0;
      logic [1:0] e;
      bq.push_back(eresp);
      m_if.awaddr = addr; m_if.awvalid = 1; m_if.wdata = data; m_if.wmask = mask;
      m_if.wvalid = (w_delay == 0); m_if.bready = 1;
      while (!b_done && cyc < 50) begin
         @(negedge clk);
         aw_now = m_if.awvalid && m_if.awready;
         w_now  = m_if.wvalid && m_if.wready;
         if (probe_aw && aw_done) begin
            check({tag, "_aw_blocked"}, 32'(m_if.awready), 32'd0);
            check({tag, "_state"}, 32'(dut.wr_state_q), w_done ? 32'd2 : 32'd1);
         end
         if (m_if.bvalid && m_if.bready) begin
            e = bq.pop_front();
            check({tag, "_bresp"}, 32'(m_if.bresp), 32'(e));
            b_done = 1;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (aw_now && !aw_done) begin
            aw_done = 1;
            if (probe_aw) m_if.awaddr = addr + 32'h100;
            else m_if.awvalid = 0;
         end
         if (w_now) begin
            w_done = 1;
            m_if.wvalid = 0;
         end else if (!w_done && cyc >= w_delay) m_if.wvalid = 1;
      end
      m_if.awvalid = 0; m_if.wvalid = 0; m_if.bready = 0;
      check({tag, "_bdone"}, 32'(b_done), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned b0, b1, c0, c1;
      bit          seen, ar_now;
      int          cyc;
      rexp_t       e;
      logic [1:0]  eb;
      rd_delay = '{1, 0}; b_delay = '{0, 0}; slv_rdata = '{32'hDEAD_BEEF, 32'h1234_5678};
      reset = 0;
      m_if.araddr = '0; m_if.arvalid = 0; m_if.rready = 0;
      m_if.awaddr = '0; m_if.awvalid = 0; m_if.wdata = '0; m_if.wmask = '0;
      m_if.wvalid = 0; m_if.bready = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      // Unmapped address 0 would give ready=1 without the reset gating.
      check("rst_arready", 32'(m_if.arready), 32'd0);
      check("rst_awready", 32'(m_if.awready), 32'd0);
      check("rst_cnt", 32'(cnt), 32'd0);
      check("rst_addr", eaddr, 32'd0);
      @(posedge clk);
      #1;
      reset = 1;
      repeat (2) @(posedge clk);
      #1;

      // 1: read from memory slave
      b1 = g_slv[1].arv_cnt; b0 = g_slv[0].ar_cnt;
      rd(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, "t1");
      check("t1_s1_arvalid", g_slv[1].arv_cnt - b1, 32'd0);
      check("t1_s0_ar", g_slv[0].ar_cnt - b0, 32'd1);

      // 2: write to MMIO, AW and W together
      b0 = g_slv[0].awv_cnt; b1 = g_slv[1].aw_cnt; c1 = g_slv[1].w_cnt;
      wr(32'hA000_03F8, 32'h41, 4'b0001, 0, 0, 2'b00, "t2");
      check("t2_s1_aw", g_slv[1].aw_cnt - b1, 32'd1);
      check("t2_s1_w", g_slv[1].w_cnt - c1, 32'd1);
      check("t2_s1_awaddr", g_slv[1].last_awaddr, 32'hA000_03F8);
      check("t2_s1_wdata", g_slv[1].last_wdata, 32'h41);
      check("t2_s1_wmask", 32'(g_slv[1].last_wmask), 32'h1);
      check("t2_s0_awvalid", g_slv[0].awv_cnt - b0, 32'd0);

      // 3: W three cycles after AW, slow B, second AW held off
      b_delay[0] = 5;
      b0 = g_slv[0].aw_cnt; c0 = g_slv[0].w_cnt; b1 = g_slv[1].awv_cnt;
      wr(32'h8000_0000, 32'h5555_AAAA, 4'hF, 3, 1, 2'b00, "t3");
      check("t3_s0_aw", g_slv[0].aw_cnt - b0, 32'd1);
      check("t3_s0_w", g_slv[0].w_cnt - c0, 32'd1);
      check("t3_s1_awvalid", g_slv[1].awv_cnt - b1, 32'd0);
      check("t3_s0_wdata", g_slv[0].last_wdata, 32'h5555_AAAA);
      b_delay[0] = 0;

      // 4: unmapped read then write
      rd(32'h1000_0000, 32'h0, 2'b11, "t4");
      wr(32'h1000_0004, 32'h77, 4'hF, 0, 0, 2'b11, "t4");
      check("t4_cnt", 32'(cnt), 32'd2);
      check("t4_addr", eaddr, 32'h1000_0004);

      // 5: saturation, then a same-cycle read/write error at 254
      for (int i = 0; i < 300; i++) rd(32'h0000_1000 + 32'(i) * 4, 32'h0, 2'b11, "t5a");
      check("t5_sat_cnt", 32'(cnt), 32'd255);
      check("t5_sat_addr", eaddr, 32'h0000_1000 + 32'd299 * 4);
      reset = 0;
      @(posedge clk);
      #1;
      reset = 1;
      @(posedge clk);
      #1;
      check("t5_rst_cnt", 32'(cnt), 32'd0);
      for (int i = 0; i < 254; i++) rd(32'h0400_0000, 32'h0, 2'b11, "t5b");
      check("t5_254", 32'(cnt), 32'd254);
      rq.push_back({32'h0, 2'b11});
      bq.push_back(2'b11);
      m_if.araddr = 32'h2000_0000; m_if.awaddr = 32'h3000_0000;
      m_if.arvalid = 1; m_if.awvalid = 1; m_if.wvalid = 1; m_if.rready = 1; m_if.bready = 1;
      @(negedge clk);
      check("tie_arready", 32'(m_if.arready), 32'd1);
      check("tie_awready", 32'(m_if.awready), 32'd1);
      check("tie_wready", 32'(m_if.wready), 32'd1);
      @(posedge clk);
      #1;
      m_if.arvalid = 0; m_if.awvalid = 0; m_if.wvalid = 0;
      check("tie_cnt", 32'(cnt), 32'd255);
      check("tie_addr", eaddr, 32'h3000_0000);
      @(negedge clk);
      check("tie_rvalid", 32'(m_if.rvalid), 32'd1);
      check("tie_bvalid", 32'(m_if.bvalid), 32'd1);
      e = rq.pop_front();
      check("tie_rdata", m_if.rdata, e.data);
      check("tie_rresp", 32'(m_if.rresp), 32'(e.resp));
      eb = bq.pop_front();
      check("tie_bresp", 32'(m_if.bresp), 32'(eb));
      @(posedge clk);
      #1;
      m_if.rready = 0; m_if.bready = 0;

      // 6: reset while a memory read response is pending
      rd_delay[0] = 2; slv_rdata[0] = 32'hCAFE_0001;
      m_if.araddr = 32'h8000_0100; m_if.arvalid = 1; m_if.rready = 0;
      seen = 0; cyc = 0;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         ar_now = m_if.arvalid && m_if.arready;
         seen = m_if.rvalid;
         if (!seen) begin
            @(posedge clk);
            #1;
            if (ar_now) m_if.arvalid = 0;
            cyc++;
         end
      end
      check("t6_pending", 32'(seen), 32'd1);
      check("t6_pending_rdata", m_if.rdata, 32'hCAFE_0001);
      @(posedge clk);
      #1;
      reset = 0;
      #1;
      check("t6_outs", 32'({m_if.arready, m_if.rvalid, m_if.awready, m_if.wready, m_if.bvalid,
                            s_if[0].arvalid, s_if[0].rready, s_if[0].awvalid, s_if[0].wvalid,
                            s_if[0].bready, s_if[1].arvalid, s_if[1].rready, s_if[1].awvalid,
                            s_if[1].wvalid, s_if[1].bready}), 32'd0);
      check("t6_state", 32'(dut.rd_state_q), 32'd0);
      check("t6_cnt", 32'(cnt), 32'd0);
      m_if.arvalid = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1;
      @(posedge clk);
      #1;
      rd(32'hA000_0020, 32'h1234_5678, 2'b00, "t6_s1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
